// File: rtl/mul_rep_add_ctrl_pkg.sv
// Shared types and defaults for the repeated-addition multiplier controller.
package mul_ctrl_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_MAX_ITER = 65535;
    localparam int STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        GET_A,
        GET_B,
        ADD,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/mul_rep_add_ctrl_if.sv
// Handshake/strobe bundle between the controller and the multiplier datapath.
// data_in is carried for the datapath side; the controller never looks at it.
interface mul_rep_add_ctrl_if #(parameter int WIDTH = 16) ();

    logic             start;
    logic             abort;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] data_in;
    logic             eqz;
    logic             LdA;
    logic             LdB;
    logic             clrP;
    logic             LdP;
    logic             decB;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] iter_cnt;

    // Requester/datapath side
    modport master (
        output start, abort, din_valid, data_in, eqz,
        input  din_ready, LdA, LdB, clrP, LdP, decB, busy, done, err, iter_cnt
    );

    // Controller side
    modport slave (
        input  start, abort, din_valid, eqz,
        output din_ready, LdA, LdB, clrP, LdP, decB, busy, done, err, iter_cnt
    );

endinterface

// File: rtl/mul_rep_add_ctrl_iter_cnt.sv
// Add-iteration counter: clear on op start, count each add, saturate at
// all-ones, and flag when the next add would exceed the iteration limit.
module mul_iter_cnt #(
    parameter int WIDTH    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] iter_cnt,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_ITER);

    logic [WIDTH-1:0] cnt;

    // Counter register; holds its value between operations.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    // A limit of zero turns the guard off entirely.
    always_comb begin
        at_limit = (MAX_ITER != 0) && (cnt >= LIMIT);
    end

    assign iter_cnt = cnt;

endmodule

// File: rtl/mul_rep_add_ctrl.sv
// Control FSM for the repeated-addition multiplier: collects A then B over the
// shared data bus, then adds A into P once per cycle until the B counter hits 0.
module mul_rep_add_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_ITER = DEF_MAX_ITER
) (
    input  logic              clk,
    input  logic              rst,
    mul_rep_add_ctrl_if.slave bus
);

    state_t           state, state_nxt;
    logic             cnt_clr, cnt_inc, at_limit;
    logic [WIDTH-1:0] cnt;
    logic             din_ready, lda, ldb, clrp, ldp, decb, done, err;

    mul_iter_cnt #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER)) u_iter_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .iter_cnt (cnt),
        .at_limit (at_limit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and Mealy strobes; abort suppresses every strobe in its cycle.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        din_ready = 1'b0;
        lda       = 1'b0;
        ldb       = 1'b0;
        clrp      = 1'b0;
        ldp       = 1'b0;
        decb      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = GET_A;
                    cnt_clr   = 1'b1;
                end
            end
            GET_A: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    din_ready = 1'b1;
                    lda       = bus.din_valid;
                    if (bus.din_valid) state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    din_ready = 1'b1;
                    ldb       = bus.din_valid;
                    clrp      = bus.din_valid;
                    if (bus.din_valid) state_nxt = ADD;
                end
            end
            ADD: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.eqz) begin
                    // B already zero: finish without an add so B=0 yields P=0
                    state_nxt = DONE;
                end else if (at_limit) begin
                    state_nxt = ERR;
                end else begin
                    ldp     = 1'b1;
                    decb    = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                done      = !bus.abort;
                state_nxt = IDLE;
            end
            ERR: begin
                err       = !bus.abort;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.din_ready = din_ready;
    assign bus.LdA       = lda;
    assign bus.LdB       = ldb;
    assign bus.clrP      = clrp;
    assign bus.LdP       = ldp;
    assign bus.decB      = decb;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;
    assign bus.err       = err;
    assign bus.iter_cnt  = cnt;

endmodule

// File: tb/tb_mul_rep_add_ctrl.sv
// Bench for mul_rep_add_ctrl: a small behavioural datapath (A, B counter, P)
// sits beside the controller; stimulus pushes expected results into a queue
// and a negedge monitor pops and checks them on every done/err pulse.
module tb_mul_rep_add_ctrl;
    import mul_ctrl_pkg::*;

    localparam int W    = 16;
    localparam int MAXI = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_rep_add_ctrl_if #(.WIDTH(W)) bus ();

    mul_rep_add_ctrl #(.WIDTH(W), .MAX_ITER(MAXI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Datapath model driven by the strobes
    logic [W-1:0] a_reg = '0;
    logic [W-1:0] b_reg = '0;
    logic [W-1:0] p_reg = '0;
    always @(posedge clk) begin
        if (bus.LdA) a_reg <= bus.data_in;
        if (bus.LdB) b_reg <= bus.data_in;
        else if (bus.decB) b_reg <= b_reg - 1'b1;
        if (bus.clrP) p_reg <= '0;
        else if (bus.LdP) p_reg <= p_reg + a_reg;
    end
    assign bus.eqz = (b_reg == '0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           is_err;
        logic [W-1:0] p;
        logic [W-1:0] it;
        int           cyc;
        int           n_ldp;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: strobe sanity each busy cycle, scoreboard compare on done/err
    int n_lda = 0, n_ldb = 0, n_ldp = 0;
    bit was_end = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (was_end) begin
                chk("idle_after_end", bus.busy, 0);
                was_end = 1'b0;
            end
            if (bus.busy) begin
                chk("strobe_excl", (bus.LdA & bus.LdB) | (bus.clrP & bus.LdP) |
                    ((bus.LdA | bus.LdB) & ~bus.din_valid), 0);
                n_lda += int'(bus.LdA);
                n_ldb += int'(bus.LdB);
                n_ldp += int'(bus.LdP);
                if (bus.done || bus.err) begin
                    was_end = 1'b1;
                    if (q.size() == 0) begin
                        chk("unexpected_end", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("err_flag", bus.err, e.is_err);
                        chk("done_flag", bus.done, !e.is_err);
                        chk("product", p_reg, e.p);
                        chk("iter_cnt", bus.iter_cnt, e.it);
                        chk("latency", cyc, e.cyc);
                        chk("ldp_pulses", n_ldp, e.n_ldp);
                        chk("lda_pulses", n_lda, 1);
                        chk("ldb_pulses", n_ldb, 1);
                    end
                end
            end else begin
                n_lda = 0;
                n_ldb = 0;
                n_ldp = 0;
            end
        end
    end

    // mode: 0 normal, 1 abort at 3rd add, 2 reset in GET_B, 3 start pulse during ADD
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int wa, input int wb, input int mode);
        int   t0, n;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.din_valid = 1'b0;
        repeat (wa) @(negedge clk);
        bus.data_in   = a;
        bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        if (mode == 2) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_busy", bus.busy, 0);
            chk("rst_strobes", {bus.din_ready, bus.LdB, bus.clrP, bus.LdP, bus.done}, 0);
            chk("rst_iter", bus.iter_cnt, 0);
            return;
        end
        repeat (wb) @(negedge clk);
        bus.data_in   = b;
        bus.din_valid = 1'b1;
        n = (int'(b) > MAXI) ? MAXI : int'(b);
        if (mode != 1) begin
            e.is_err = (int'(b) > MAXI);
            e.p      = W'(int'(a) * n);
            e.it     = W'(n);
            e.n_ldp  = n;
            e.cyc    = t0 + 1 + 2 + wa + wb + n + 1;
            q.push_back(e);
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
        if (mode == 1) begin
            for (int i = 0; i < 50 && bus.iter_cnt != 3; i++) @(negedge clk);
            chk("reach_iter3", bus.iter_cnt, 3);
            bus.abort = 1'b1;
            #1;
            chk("abort_strobes", {bus.LdP, bus.decB, bus.din_ready, bus.done, bus.err}, 0);
            @(negedge clk);
            bus.abort = 1'b0;
            chk("abort_idle", bus.busy, 0);
            chk("abort_iter_hold", bus.iter_cnt, 3);
            return;
        end
        if (mode == 3) begin
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
        chk("op_finished", bus.busy, 0);
        if (mode == 3) begin
            repeat (3) @(negedge clk);
            chk("start_not_queued", bus.busy, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.din_valid = 1'b0;
        bus.data_in   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_iter", bus.iter_cnt, 0);
        chk("reset_strobes", {bus.din_ready, bus.LdA, bus.LdB, bus.clrP, bus.LdP,
                              bus.decB, bus.done, bus.err}, 0);
        rst = 1'b0;

        run_op(16'd7,    16'd5,  0, 0, 0);   // P=35, 8 cycles
        run_op(16'd1234, 16'd0,  0, 0, 0);   // P=0, 3 cycles
        run_op(16'd3,    16'd4,  4, 3, 0);   // stalls, P=12
        run_op(16'd2,    16'd10, 0, 0, 0);   // err after 8 adds
        run_op(16'd5,    16'd8,  0, 0, 0);   // B at limit completes, P=40
        run_op(16'd2,    16'd9,  0, 0, 1);   // abort at 3rd add (P left at 6)
        run_op(16'd9,    16'd1,  0, 0, 2);   // reset in GET_B
        run_op(16'd6,    16'd6,  0, 0, 0);   // P=36 proves clrP
        run_op(16'hFFFF, 16'd2,  0, 0, 3);   // wrap to FFFE, stray start ignored

        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_idle", bus.busy, 0);
        chk("iter_hold_idle", bus.iter_cnt, 2);

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
